fpu_cvt_to_int_pipe: RTL and testbench

- Pipelined, parametrised float-to-integer converter for the FPU arithmetic path (FCVT.W/WU, and FCVT.L/LU when INT_W=64).
- Takes raw IEEE-754 bits of any width and unpacks them internally, including subnormals.
- Rounds per the RISC-V rm field, saturates per the RISC-V rules, and produces NV/NX exception flags.
- Uses a valid/ready handshake with a fixed 3-cycle latency and whole-pipe stall on backpressure.

---
 rtl/fpu_cvt_to_int_pipe.sv | 245 ++++++++++++++++++++++++
 tb/tb_fpu_cvt_to_int_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_to_int_pipe.sv
// rtl/fpu_cvt_to_int_pipe.sv - pipelined IEEE-754 to integer converter (FCVT.W/WU/L/LU)
module fpu_cvt_to_int_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [EXP_W+MAN_W:0]   in_op_i,
   input  logic                   in_unsigned_i,
   input  logic [2:0]             in_rm_i,
   input  logic [TAG_W-1:0]       in_tag_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [INT_W-1:0]       out_result_o,
   output logic [4:0]             out_fflags_o,
   output logic [TAG_W-1:0]       out_tag_o
);

   // Effective exponent is signed and needs headroom above EXP_W bits.
   localparam int EE_W = EXP_W + 2;
   // Alignment vector: {integer, guard, round, MAN_W+1 sticky bits}.
   localparam int CW   = INT_W + MAN_W + 3;
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;

   localparam logic signed [EE_W-1:0] BIAS_S  = EE_W'(BIAS);
   localparam logic signed [EE_W-1:0] EXP_M1  = EE_W'(-1);
   localparam logic signed [EE_W-1:0] EXP_INT = EE_W'(INT_W);
   localparam logic signed [EE_W-1:0] EXP_P3  = EE_W'(3);

   localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic [INT_W-1:0] ONES = {INT_W{1'b1}};

   logic adv;

   // ---------------- S1: unpack ----------------
   logic                   u_sign;
   logic [EXP_W-1:0]       u_exp;
   logic [MAN_W-1:0]       u_frac;
   logic                   u_exp_zero;
   logic                   u_exp_ones;
   logic                   u_frac_zero;
   logic [EXP_W-1:0]       u_exp_eff;
   logic signed [EE_W-1:0] u_eexp;

   logic                   s1_valid;
   logic                   s1_sign;
   logic                   s1_nan;
   logic                   s1_inf;
   logic                   s1_zero;
   logic                   s1_small;
   logic                   s1_big;
   logic [MAN_W:0]         s1_sig;
   logic signed [EE_W-1:0] s1_eexp;
   logic                   s1_uns;
   logic [2:0]             s1_rm;
   logic [TAG_W-1:0]       s1_tag;

   assign adv        = !out_valid_o || out_ready_i;
   assign in_ready_o = adv;

   // Field split and classification of the raw operand; subnormals use exponent 1.
   always_comb begin
      u_sign      = in_op_i[EXP_W+MAN_W];
      u_exp       = in_op_i[EXP_W+MAN_W-1:MAN_W];
      u_frac      = in_op_i[MAN_W-1:0];
      u_exp_zero  = ~|u_exp;
      u_exp_ones  = &u_exp;
      u_frac_zero = ~|u_frac;
      u_exp_eff   = u_exp_zero ? {{(EXP_W-1){1'b0}}, 1'b1} : u_exp;
      u_eexp      = $signed({2'b00, u_exp_eff}) - BIAS_S;
   end

   // S1 register: unpacked operand plus range hints for the aligner.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_small <= 1'b0;
         s1_big   <= 1'b0;
         s1_sig   <= '0;
         s1_eexp  <= '0;
         s1_uns   <= 1'b0;
         s1_rm    <= '0;
         s1_tag   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid_i;
         s1_sign  <= u_sign;
         s1_nan   <= u_exp_ones && !u_frac_zero;
         s1_inf   <= u_exp_ones && u_frac_zero;
         s1_zero  <= u_exp_zero && u_frac_zero;
         s1_small <= u_eexp < EXP_M1;
         s1_big   <= u_eexp >= EXP_INT;
         s1_sig   <= {!u_exp_zero, u_frac};
         s1_eexp  <= u_eexp;
         s1_uns   <= in_unsigned_i;
         s1_rm    <= in_rm_i;
         s1_tag   <= in_tag_i;
      end
   end

   // ---------------- S2: align ----------------
   logic                   a_shift_en;
   logic signed [EE_W-1:0] a_eexp_p3;
   logic [EE_W-1:0]        a_shamt;
   logic [CW-1:0]          a_vec;

   logic                   s2_valid;
   logic                   s2_sign;
   logic                   s2_nan;
   logic                   s2_inf;
   logic                   s2_zero;
   logic                   s2_big;
   logic [INT_W-1:0]       s2_int;
   logic                   s2_g;
   logic                   s2_r;
   logic                   s2_s;
   logic                   s2_uns;
   logic [2:0]             s2_rm;
   logic [TAG_W-1:0]       s2_tag;

   // One left shift by (exp+3) places the significand LSB relative to the sticky
   // region, so exponents above MAN_W shift left and smaller ones spill into
   // guard/round/sticky. Out-of-range operands use shift 0: with the significand
   // at the bottom only the sticky OR is non-zero, which is exactly the too_small
   // case, and too_big results are overridden in S3.
   always_comb begin
      a_shift_en = !s1_small && !s1_big;
      a_eexp_p3  = s1_eexp + EXP_P3;
      a_shamt    = a_shift_en ? a_eexp_p3 : '0;
      a_vec      = {{(CW-MAN_W-1){1'b0}}, s1_sig} << a_shamt;
   end

   // S2 register: aligned integer with guard, round and sticky.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_nan   <= 1'b0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
         s2_big   <= 1'b0;
         s2_int   <= '0;
         s2_g     <= 1'b0;
         s2_r     <= 1'b0;
         s2_s     <= 1'b0;
         s2_uns   <= 1'b0;
         s2_rm    <= '0;
         s2_tag   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_nan   <= s1_nan;
         s2_inf   <= s1_inf;
         s2_zero  <= s1_zero;
         s2_big   <= s1_big;
         s2_int   <= a_vec[CW-1:MAN_W+3];
         s2_g     <= a_vec[MAN_W+2];
         s2_r     <= a_vec[MAN_W+1];
         s2_s     <= |a_vec[MAN_W:0];
         s2_uns   <= s1_uns;
         s2_rm    <= s1_rm;
         s2_tag   <= s1_tag;
      end
   end

   // ---------------- S3: round, saturate, flag ----------------
   logic               r_inexact;
   logic               r_incr;
   logic [INT_W:0]     r_mag;
   logic               r_oor;
   logic [INT_W-1:0]   r_result;
   logic               r_nv;
   logic               r_nx;

   // Rounding increment from L/G/R/S; reserved rm encodings truncate.
   always_comb begin
      r_inexact = s2_g || s2_r || s2_s;
      r_incr    = 1'b0;
      case (s2_rm)
         3'b000:  r_incr = s2_g && (s2_r || s2_s || s2_int[0]);
         3'b010:  r_incr = s2_sign && r_inexact;
         3'b011:  r_incr = !s2_sign && r_inexact;
         3'b100:  r_incr = s2_g;
         default: r_incr = 1'b0;
      endcase
      r_mag = {1'b0, s2_int} + {{INT_W{1'b0}}, r_incr};
   end

   // Range check on the rounded magnitude; -2^(INT_W-1) is the one legal
   // magnitude with the top bit set for signed negative results.
   always_comb begin
      r_oor = s2_big;
      if (s2_uns) begin
         if (s2_sign) r_oor = r_oor || (r_mag != '0);
         else         r_oor = r_oor || r_mag[INT_W];
      end else begin
         if (s2_sign) r_oor = r_oor || r_mag[INT_W] || (r_mag[INT_W-1] && (|r_mag[INT_W-2:0]));
         else         r_oor = r_oor || r_mag[INT_W] || r_mag[INT_W-1];
      end
   end

   // Final result selection: NaN, then Inf/out-of-range saturation, then zero, then the value.
   always_comb begin
      r_result = '0;
      r_nv     = 1'b0;
      r_nx     = 1'b0;
      if (s2_nan) begin
         r_result = s2_uns ? ONES : SMAX;
         r_nv     = 1'b1;
      end else if (s2_inf || r_oor) begin
         r_nv = 1'b1;
         if (s2_uns) r_result = s2_sign ? '0 : ONES;
         else        r_result = s2_sign ? SMIN : SMAX;
      end else if (s2_zero) begin
         r_result = '0;
      end else begin
         r_result = (s2_sign && !s2_uns) ? -r_mag[INT_W-1:0] : r_mag[INT_W-1:0];
         r_nx     = r_inexact;
      end
   end

   // Output register, held while the consumer stalls.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         out_valid_o  <= 1'b0;
         out_result_o <= '0;
         out_fflags_o <= '0;
         out_tag_o    <= '0;
      end else if (adv) begin
         out_valid_o  <= s2_valid;
         out_result_o <= r_result;
         out_fflags_o <= {r_nv, 3'b000, r_nx};
         out_tag_o    <= s2_tag;
      end
   end

endmodule

// File: tb/tb_fpu_cvt_to_int_pipe.sv
// tb/tb_fpu_cvt_to_int_pipe.sv - scoreboard bench for fpu_cvt_to_int_pipe (32- and 64-bit builds)
module tb_fpu_cvt_to_int_pipe;

   localparam logic [2:0] RNE = 3'b000;
   localparam logic [2:0] RTZ = 3'b001;
   localparam logic [2:0] RDN = 3'b010;
   localparam logic [2:0] RUP = 3'b011;
   localparam logic [2:0] RMM = 3'b100;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  ff;
      logic [4:0]  tag;
      int          acc;
      bit          lat;
   } exp_t;

   logic clk;
   logic reset_i;

   logic        v32, rdy32, uns32, ordy32, ov32;
   logic [31:0] op32, res32;
   logic [2:0]  rm32;
   logic [4:0]  tag32, ff32, otag32;

   logic        v64, rdy64, uns64, ordy64, ov64;
   logic [63:0] op64, res64;
   logic [2:0]  rm64;
   logic [4:0]  tag64, ff64, otag64;

   exp_t q32[$];
   exp_t q64[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   logic [4:0] tg = 5'd10;

   fpu_cvt_to_int_pipe dut32 (
      .clk_i(clk), .reset_i(reset_i),
      .in_valid_i(v32), .in_ready_o(rdy32), .in_op_i(op32),
      .in_unsigned_i(uns32), .in_rm_i(rm32), .in_tag_i(tag32),
      .out_valid_o(ov32), .out_ready_i(ordy32), .out_result_o(res32),
      .out_fflags_o(ff32), .out_tag_o(otag32)
   );

   fpu_cvt_to_int_pipe #(.EXP_W(11), .MAN_W(52), .INT_W(64), .TAG_W(5)) dut64 (
      .clk_i(clk), .reset_i(reset_i),
      .in_valid_i(v64), .in_ready_o(rdy64), .in_op_i(op64),
      .in_unsigned_i(uns64), .in_rm_i(rm64), .in_tag_i(tag64),
      .out_valid_o(ov64), .out_ready_i(ordy64), .out_result_o(res64),
      .out_fflags_o(ff64), .out_tag_o(otag64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      checks++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic send(input bit w64, input logic [63:0] op, input bit uns, input logic [2:0] rm,
                       input logic [4:0] tag, input logic [63:0] res, input logic [4:0] ff, input bit lat);
      exp_t e;
      int   n;
      bit   ok;
      if (w64) begin
         op64 = op; uns64 = uns; rm64 = rm; tag64 = tag; v64 = 1'b1;
      end else begin
         op32 = op[31:0]; uns32 = uns; rm32 = rm; tag32 = tag; v32 = 1'b1;
      end
      n = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         @(negedge clk);
         if ((w64 ? rdy64 : rdy32) === 1'b1) ok = 1'b1;
         else n++;
      end
      if (!ok) begin
         fail("send_timeout");
      end else begin
         e.res = res; e.ff = ff; e.tag = tag; e.acc = cyc + 1; e.lat = lat;
         if (w64) q64.push_back(e);
         else     q32.push_back(e);
         @(posedge clk);
         #1;
      end
      if (w64) v64 = 1'b0;
      else     v32 = 1'b0;
   endtask

   task automatic s32(input logic [31:0] op, input bit uns, input logic [2:0] rm,
                      input logic [31:0] res, input logic [4:0] ff);
      send(1'b0, {32'h0, op}, uns, rm, tg, {32'h0, res}, ff, 1'b0);
      tg = tg + 5'd1;
   endtask

   task automatic s64(input logic [63:0] op, input bit uns, input logic [2:0] rm,
                      input logic [63:0] res, input logic [4:0] ff);
      send(1'b1, op, uns, rm, tg, res, ff, 1'b0);
      tg = tg + 5'd1;
   endtask

   // Monitor for the 32-bit converter.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_i === 1'b1 && ov32 === 1'b1 && ordy32 === 1'b1) begin
            if (q32.size() == 0) begin
               fail("unexpected_out32");
            end else begin
               e = q32.pop_front();
               check("res32", 64'(res32), e.res);
               check("fflags32", 64'(ff32), 64'(e.ff));
               check("tag32", 64'(otag32), 64'(e.tag));
               if (e.lat) check("latency32", 64'(cyc + 1 - e.acc), 64'd3);
            end
         end
      end
   end

   // Monitor for the 64-bit converter.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_i === 1'b1 && ov64 === 1'b1 && ordy64 === 1'b1) begin
            if (q64.size() == 0) begin
               fail("unexpected_out64");
            end else begin
               e = q64.pop_front();
               check("res64", res64, e.res);
               check("fflags64", 64'(ff64), 64'(e.ff));
               check("tag64", 64'(otag64), 64'(e.tag));
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (q32.size() != 0 || q64.size() != 0) fail("drain_timeout");
      #1;
   endtask

   initial begin
      reset_i = 1'b0;
      v32 = 1'b0; op32 = '0; uns32 = 1'b0; rm32 = '0; tag32 = '0; ordy32 = 1'b1;
      v64 = 1'b0; op64 = '0; uns64 = 1'b0; rm64 = '0; tag64 = '0; ordy64 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(ov32), 64'd0);
      check("rst_result", 64'(res32), 64'd0);
      check("rst_fflags", 64'(ff32), 64'd0);
      check("rst_tag", 64'(otag32), 64'd0);
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(rdy32), 64'd1);
      @(posedge clk);
      #1;

      // Directed 32-bit vectors, back-to-back with the consumer always ready.
      send(1'b0, 64'h40490FDB, 1'b0, RNE, tg, 64'd3, 5'h01, 1'b1);
      tg = tg + 5'd1;
      s32(32'h40490FDB, 1'b0, RUP, 32'd4, 5'h01);
      s32(32'h40200000, 1'b0, RNE, 32'd2, 5'h01);
      s32(32'h40200000, 1'b0, RMM, 32'd3, 5'h01);
      s32(32'h40200000, 1'b0, RDN, 32'd2, 5'h01);
      s32(32'hC0200000, 1'b0, RDN, 32'hFFFFFFFD, 5'h01);
      s32(32'hBF800000, 1'b1, RNE, 32'h0, 5'h10);
      s32(32'hBE99999A, 1'b1, RTZ, 32'h0, 5'h01);
      s32(32'h4F000000, 1'b0, RNE, 32'h7FFFFFFF, 5'h10);
      s32(32'hCF000000, 1'b0, RNE, 32'h80000000, 5'h00);
      s32(32'h7FC00000, 1'b0, RNE, 32'h7FFFFFFF, 5'h10);
      s32(32'h7FC00000, 1'b1, RNE, 32'hFFFFFFFF, 5'h10);
      s32(32'hFF800000, 1'b1, RNE, 32'h0, 5'h10);
      s32(32'h7F800000, 1'b0, RNE, 32'h7FFFFFFF, 5'h10);
      s32(32'h00000001, 1'b0, RUP, 32'd1, 5'h01);
      s32(32'h80000001, 1'b0, RDN, 32'hFFFFFFFF, 5'h01);
      s32(32'h80000000, 1'b1, RNE, 32'h0, 5'h00);
      s32(32'h3F000000, 1'b0, RNE, 32'h0, 5'h01);
      s32(32'h3F000000, 1'b0, RMM, 32'd1, 5'h01);
      s32(32'h40200000, 1'b0, 3'b101, 32'd2, 5'h01);
      s32(32'h3FC00000, 1'b0, RNE, 32'd2, 5'h01);
      s32(32'hBFC00000, 1'b0, RNE, 32'hFFFFFFFE, 5'h01);
      s32(32'h3F800000, 1'b0, RNE, 32'd1, 5'h00);
      s32(32'h4F800000, 1'b1, RNE, 32'hFFFFFFFF, 5'h10);
      s32(32'h4F7FFFFF, 1'b1, RNE, 32'hFFFFFF00, 5'h00);
      s32(32'h4F7FFFFF, 1'b0, RNE, 32'h7FFFFFFF, 5'h10);
      s32(32'h4EFFFFFF, 1'b0, RNE, 32'h7FFFFF80, 5'h00);
      drain();

      // Backpressure: five ops against a stalled consumer.
      ordy32 = 1'b0;
      fork
         begin
            send(1'b0, 64'h3F800000, 1'b0, RNE, 5'd1, 64'd1, 5'h00, 1'b0);
            send(1'b0, 64'h40000000, 1'b0, RNE, 5'd2, 64'd2, 5'h00, 1'b0);
            send(1'b0, 64'h40400000, 1'b0, RNE, 5'd3, 64'd3, 5'h00, 1'b0);
            send(1'b0, 64'h40800000, 1'b0, RNE, 5'd4, 64'd4, 5'h00, 1'b0);
            send(1'b0, 64'h40A00000, 1'b0, RNE, 5'd5, 64'd5, 5'h00, 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("bp_in_ready", 64'(rdy32), 64'd0);
               check("bp_hold_valid", 64'(ov32), 64'd1);
               check("bp_hold_tag", 64'(otag32), 64'd1);
               check("bp_hold_res", 64'(res32), 64'd1);
            end
            @(posedge clk);
            #1;
            ordy32 = 1'b1;
            for (int i = 1; i <= 5; i++) begin
               @(negedge clk);
               check("bp_stream_valid", 64'(ov32), 64'd1);
               check("bp_stream_tag", 64'(otag32), 64'(i));
               @(posedge clk);
            end
         end
      join
      drain();

      // Reset with three operations in flight.
      ordy32 = 1'b0;
      send(1'b0, 64'h40000000, 1'b0, RNE, 5'd6, 64'd2, 5'h00, 1'b0);
      send(1'b0, 64'h40400000, 1'b0, RNE, 5'd7, 64'd3, 5'h00, 1'b0);
      send(1'b0, 64'h40800000, 1'b0, RNE, 5'd8, 64'd4, 5'h00, 1'b0);
      reset_i = 1'b0;
      q32.delete();
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      ordy32 = 1'b1;
      @(negedge clk);
      check("midrst_valid", 64'(ov32), 64'd0);
      check("midrst_in_ready", 64'(rdy32), 64'd1);
      repeat (6) @(posedge clk);
      #1;
      send(1'b0, 64'h40A00000, 1'b0, RNE, 5'd9, 64'd5, 5'h00, 1'b1);
      drain();

      // 64-bit build.
      s64(64'h43E0000000000000, 1'b0, RNE, 64'h7FFFFFFFFFFFFFFF, 5'h10);
      s64(64'h43E0000000000000, 1'b1, RNE, 64'h8000000000000000, 5'h00);
      s64(64'hC3E0000000000000, 1'b0, RNE, 64'h8000000000000000, 5'h00);
      s64(64'h43F0000000000000, 1'b1, RNE, 64'hFFFFFFFFFFFFFFFF, 5'h10);
      s64(64'h400921FB54442D18, 1'b0, RNE, 64'd3, 5'h01);
      s64(64'hC004000000000000, 1'b0, RDN, 64'hFFFFFFFFFFFFFFFD, 5'h01);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
